reg_writeback: RTL and testbench

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_if.sv | 41 ++++
 rtl/reg_writeback.sv | 104 ++++++++++
 tb/tb_reg_writeback.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_if.sv
//------------------------------------------------------------------------------
// reg_writeback_if : ALU/load result inputs, register-file write port, hazard query
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface reg_writeback_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_reg;
  logic [31:0] ld_data;
  logic        regwrite;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic [4:0]  pend_reg;
  logic        pend_hit;

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  ld_valid, ld_reg, ld_data,
    input  pend_reg,
    output alu_ready, ld_ready,
    output regwrite, wrreg, wrdata,
    output pend_hit
  );

  modport master (
    output alu_valid, alu_reg, alu_data,
    output ld_valid, ld_reg, ld_data,
    output pend_reg,
    input  alu_ready, ld_ready,
    input  regwrite, wrreg, wrdata,
    input  pend_hit
  );
endinterface

`default_nettype wire

// File: rtl/reg_writeback.sv
//------------------------------------------------------------------------------
// reg_writeback : register-file write arbiter, ALU priority over a load FIFO
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  reg_writeback_if.slave wb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [4:0]    ent_reg  [DEPTH];
  logic [31:0]   ent_data [DEPTH];

  logic          out_we;
  logic [4:0]    out_reg;
  logic [31:0]   out_data;

  logic full;
  logic empty;
  logic alu_xfer;
  logic ld_xfer;
  logic push;
  logic pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  assign wb.alu_ready = !full;
  assign wb.ld_ready  = !full;

  assign alu_xfer = wb.alu_valid && !full;
  assign ld_xfer  = wb.ld_valid && !full;
  // Loads to r0 are accepted but never stored.
  assign push     = ld_xfer && (wb.ld_reg != 5'd0);
  // A full FIFO drops alu_ready, so the head is guaranteed to drain.
  assign pop      = !alu_xfer && !empty;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ent_reg[tail]  <= wb.ld_reg;
      ent_data[tail] <= wb.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      out_we   <= 1'b0;
      out_reg  <= 5'd0;
      out_data <= 32'd0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (alu_xfer && (wb.alu_reg != 5'd0)) begin
        out_we   <= 1'b1;
        out_reg  <= wb.alu_reg;
        out_data <= wb.alu_data;
      end else if (pop) begin
        out_we   <= 1'b1;
        out_reg  <= ent_reg[head];
        out_data <= ent_data[head];
      end else begin
        out_we   <= 1'b0;
      end
    end
  end

  assign wb.regwrite = out_we;
  assign wb.wrreg    = out_reg;
  assign wb.wrdata   = out_data;

  // An entry is live when its distance from head is below the occupancy.
  logic [DEPTH-1:0] hit_vec;

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PW-1:0] offset;
    assign offset     = PW'(i) - head;
    assign hit_vec[i] = ({1'b0, offset} < count) && (ent_reg[i] == wb.pend_reg);
  end

  assign wb.pend_hit = (wb.pend_reg != 5'd0) && (|hit_vec);

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
//------------------------------------------------------------------------------
// tb_reg_writeback : directed vector table plus reset and idle sequences
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_writeback;

  logic clk = 1'b0;
  logic reset;

  reg_writeback_if bus();

  reg_writeback #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic [4:0]  pr;
    logic        e_ardy;
    logic        e_lrdy;
    logic        e_hit;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld, input logic [4:0] pr,
                     input logic ea, input logic el, input logic eh,
                     input logic erw, input logic [4:0] ewr, input logic [31:0] ewd);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = ar; v.ad = ad;
    v.lv = lv; v.lr = lr; v.ld = ld; v.pr = pr;
    v.e_ardy = ea; v.e_lrdy = el; v.e_hit = eh;
    v.e_rw = erw; v.e_wr = ewr; v.e_wd = ewd;
    vecs.push_back(v);
  endtask

  task automatic drive_idle(input logic [4:0] pr);
    bus.alu_valid = 1'b0; bus.alu_reg = 5'd0; bus.alu_data = 32'd0;
    bus.ld_valid  = 1'b0; bus.ld_reg  = 5'd0; bus.ld_data  = 32'd0;
    bus.pend_reg  = pr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset         = v.rst;
    bus.alu_valid = v.av; bus.alu_reg = v.ar; bus.alu_data = v.ad;
    bus.ld_valid  = v.lv; bus.ld_reg  = v.lr; bus.ld_data  = v.ld;
    bus.pend_reg  = v.pr;
    #2;
    check($sformatf("v%0d alu_ready", idx), 32'(bus.alu_ready), 32'(v.e_ardy));
    check($sformatf("v%0d ld_ready", idx),  32'(bus.ld_ready),  32'(v.e_lrdy));
    check($sformatf("v%0d pend_hit", idx),  32'(bus.pend_hit),  32'(v.e_hit));
    @(posedge clk);
    #1;
    check($sformatf("v%0d regwrite", idx), 32'(bus.regwrite), 32'(v.e_rw));
    check($sformatf("v%0d wrreg", idx),    32'(bus.wrreg),    32'(v.e_wr));
    check($sformatf("v%0d wrdata", idx),   bus.wrdata,        v.e_wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   rst av ar  ad          lv lr  ld           pr   ard lrd hit  rw wr  wd
    // Single ALU write, then idle hold
    add(0, 1, 8,  32'hA5,     0, 0,  32'h0,      0,   1, 1, 0,  1, 8,  32'hA5);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      0,   1, 1, 0,  0, 8,  32'hA5);
    // Both sources target r0
    add(0, 1, 0,  32'hDEAD,   1, 0,  32'hBEEF,   0,   1, 1, 0,  0, 8,  32'hA5);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      0,   1, 1, 0,  0, 8,  32'hA5);
    // Hazard query on a queued load
    add(0, 0, 0,  32'h0,      1, 11, 32'hB0B,    11,  1, 1, 0,  0, 8,  32'hA5);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      11,  1, 1, 1,  1, 11, 32'hB0B);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      11,  1, 1, 0,  0, 11, 32'hB0B);
    add(0, 1, 5,  32'h55,     1, 11, 32'hC,      11,  1, 1, 0,  1, 5,  32'h55);
    add(0, 1, 6,  32'h66,     0, 0,  32'h0,      11,  1, 1, 1,  1, 6,  32'h66);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      11,  1, 1, 1,  1, 11, 32'hC);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      11,  1, 1, 0,  0, 11, 32'hC);
    // Fill to full behind ALU traffic, then drain in order
    add(0, 1, 20, 32'h20,     1, 1,  32'h101,    0,   1, 1, 0,  1, 20, 32'h20);
    add(0, 1, 21, 32'h21,     1, 2,  32'h102,    0,   1, 1, 0,  1, 21, 32'h21);
    add(0, 1, 22, 32'h22,     1, 3,  32'h103,    0,   1, 1, 0,  1, 22, 32'h22);
    add(0, 1, 23, 32'h23,     1, 4,  32'h104,    3,   1, 1, 1,  1, 23, 32'h23);
    add(0, 1, 24, 32'h24,     1, 5,  32'h105,    4,   0, 0, 1,  1, 1,  32'h101);
    add(0, 1, 24, 32'h24,     0, 0,  32'h0,      1,   1, 1, 0,  1, 24, 32'h24);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      2,   1, 1, 1,  1, 2,  32'h102);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      2,   1, 1, 0,  1, 3,  32'h103);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      2,   1, 1, 0,  1, 4,  32'h104);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      0,   1, 1, 0,  0, 4,  32'h104);
    // Push and pop in the same cycle
    add(0, 0, 0,  32'h0,      1, 7,  32'h707,    0,   1, 1, 0,  0, 4,  32'h104);
    add(0, 0, 0,  32'h0,      1, 8,  32'h808,    7,   1, 1, 1,  1, 7,  32'h707);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      7,   1, 1, 0,  1, 8,  32'h808);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      0,   1, 1, 0,  0, 8,  32'h808);
    // Continuous ALU and load streams: ALU stalls only when full
    add(0, 1, 12, 32'h12,     1, 9,  32'h909,    0,   1, 1, 0,  1, 12, 32'h12);
    add(0, 1, 13, 32'h13,     1, 10, 32'hA0A,    0,   1, 1, 0,  1, 13, 32'h13);
    add(0, 1, 14, 32'h14,     1, 15, 32'hF0F,    0,   1, 1, 0,  1, 14, 32'h14);
    add(0, 1, 16, 32'h16,     1, 17, 32'h1717,   9,   1, 1, 1,  1, 16, 32'h16);
    add(0, 1, 18, 32'h18,     1, 19, 32'h1919,   9,   0, 0, 1,  1, 9,  32'h909);
    add(0, 1, 18, 32'h18,     1, 19, 32'h1919,   9,   1, 1, 0,  1, 18, 32'h18);
    add(0, 1, 25, 32'h25,     0, 0,  32'h0,      0,   0, 0, 0,  1, 10, 32'hA0A);
    // Reset with three entries queued; transfers in the reset cycle are dropped
    add(1, 1, 26, 32'h26,     1, 27, 32'h2727,   15,  1, 1, 1,  0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      15,  1, 1, 0,  0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      17,  1, 1, 0,  0, 0,  32'h0);
    add(0, 0, 0,  32'h0,      0, 0,  32'h0,      19,  1, 1, 0,  0, 0,  32'h0);

    reset = 1'b1;
    drive_idle(5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset regwrite",  32'(bus.regwrite),  32'd0);
    check("reset wrreg",     32'(bus.wrreg),     32'd0);
    check("reset wrdata",    bus.wrdata,         32'd0);
    check("reset alu_ready", 32'(bus.alu_ready), 32'd1);
    check("reset ld_ready",  32'(bus.ld_ready),  32'd1);
    check("reset pend_hit",  32'(bus.pend_hit),  32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // No stale write may surface after the reset cleared the queue
    reset = 1'b0;
    drive_idle(5'd17);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle%0d regwrite", i), 32'(bus.regwrite), 32'd0);
      check($sformatf("idle%0d pend_hit", i), 32'(bus.pend_hit), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
